// File: rtl/vm1_bus_slave.sv
// Q-bus style slave for the vm1 core: RAM port, two I/O registers (177714/177716),
// and a bus-timeout error for unmapped cycles.

module vm1_bus_slave_lane #(
  parameter int LANE = 0
) (
  input  logic        byte_op,
  input  logic        a0,
  input  logic [15:0] wdata_in,
  output logic        be,
  output logic [7:0]  wbyte
);
  // Byte ops replicate the addressed byte onto both lanes; only the addressed lane is enabled.
  always_comb begin
    be    = !byte_op || (a0 == 1'(LANE));
    wbyte = byte_op ? (a0 ? wdata_in[15:8] : wdata_in[7:0]) : wdata_in[LANE*8 +: 8];
  end
endmodule

module vm1_bus_slave #(
  parameter logic [15:0] RAM_TOP     = 16'o100000,
  parameter int          WAIT_STATES = 0,
  parameter int          TIMEOUT     = 63
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  input  logic        SYNC,
  input  logic        DIN,
  input  logic        DOUT,
  input  logic        WTBT,
  output logic        RPLY,
  output logic        error_o,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_en,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [15:0] port_o,
  input  logic [15:0] sys_i,
  output logic [15:0] sys_o
);
  localparam int          NUM_LANES = 2;
  localparam logic [15:0] PORT_ADDR = 16'o177714;
  localparam logic [15:0] SYS_ADDR  = 16'o177716;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_WAIT, S_REPLY, S_TOUT, S_ERR, S_HOLD
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        byte_op;
    logic        wr;
    logic        is_reg;
  } req_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  req_t       req;
  logic       armed, armed_n;
  logic       sync_lost, sync_lost_n;
  logic       start, complete;
  logic       ram_hit, reg_hit, valid_cmd, sel_sys;

  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wb;

  assign valid_cmd = DIN ^ DOUT;
  assign ram_hit   = addr_i < RAM_TOP;
  assign reg_hit   = (addr_i[15:1] == PORT_ADDR[15:1]) || (addr_i[15:1] == SYS_ADDR[15:1]);
  assign sel_sys   = req.addr[15:1] == SYS_ADDR[15:1];

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      vm1_bus_slave_lane #(.LANE(l)) u_lane (
        .byte_op  (req.byte_op),
        .a0       (req.addr[0]),
        .wdata_in (req.data),
        .be       (lane_be[l]),
        .wbyte    (lane_wb[l])
      );
    end
  endgenerate

  assign mem_en    = state == S_ACCESS;
  assign mem_we    = mem_en && req.wr;
  assign mem_be    = mem_en ? lane_be : '0;
  assign mem_addr  = req.addr[15:1];
  assign mem_wdata = lane_wb;
  assign RPLY      = state == S_REPLY;
  assign error_o   = state == S_ERR;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    armed_n     = armed;
    sync_lost_n = sync_lost;
    start       = 1'b0;
    complete    = 1'b0;
    case (state)
      S_IDLE: begin
        sync_lost_n = 1'b0;
        if (!SYNC) armed_n = 1'b1;
        else if (armed) begin
          // A new cycle needs IDLE to have seen SYNC low since the last one.
          start   = 1'b1;
          armed_n = 1'b0;
          if (valid_cmd && ram_hit) state_n = S_ACCESS;
          else if (valid_cmd && reg_hit) begin
            state_n = S_WAIT;
            cnt_n   = 8'(WAIT_STATES);
          end else begin
            state_n = S_TOUT;
            cnt_n   = 8'(TIMEOUT);
          end
        end
      end
      S_ACCESS: begin
        if (!SYNC) sync_lost_n = 1'b1;
        state_n = S_WAIT;
        cnt_n   = 8'(WAIT_STATES);
      end
      S_WAIT: begin
        if (!SYNC) sync_lost_n = 1'b1;
        if (cnt == 8'd0) begin
          // The access always completes; only the reply is dropped if the master left.
          complete = 1'b1;
          state_n  = (sync_lost || !SYNC) ? S_IDLE : S_REPLY;
        end else cnt_n = cnt - 8'd1;
      end
      S_REPLY: if (!SYNC) state_n = S_IDLE;
      S_TOUT: begin
        if (!SYNC) state_n = S_IDLE;
        else if (cnt == 8'd0) state_n = S_ERR;
        else cnt_n = cnt - 8'd1;
      end
      S_ERR:  state_n = S_HOLD;
      S_HOLD: if (!SYNC) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req       <= '0;
      armed     <= 1'b0;
      sync_lost <= 1'b0;
      data_o    <= '0;
      port_o    <= '0;
      sys_o     <= '0;
    end else if (ce) begin
      state     <= state_n;
      cnt       <= cnt_n;
      armed     <= armed_n;
      sync_lost <= sync_lost_n;
      if (start) req <= '{addr: addr_i, data: data_i, byte_op: WTBT, wr: DOUT,
                          is_reg: reg_hit && !ram_hit};
      if (complete && !req.wr)
        data_o <= req.is_reg ? (sel_sys ? sys_i : port_o) : mem_rdata;
      if (complete && req.wr && req.is_reg) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_be[i]) begin
            if (sel_sys) sys_o[i*8 +: 8]  <= lane_wb[i];
            else         port_o[i*8 +: 8] <= lane_wb[i];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_vm1_bus_slave.sv
// Directed bench for vm1_bus_slave: a zero-wait instance driven from a vector table,
// and a three-wait instance with a toggling clock enable for timing corners.

module tb_vm1_bus_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, ce0, sync0, din0, dout0, wtbt0, rply0, err0, men0, mwe0, clr0;
  logic [15:0] addr0, wdat0, sys0, dat0, port0, syso0, mwd0, mrd0;
  logic [14:0] ma0;
  logic [1:0]  mbe0;

  logic        rst3_n, sync3, din3, dout3, wtbt3, rply3, err3, men3, mwe3;
  logic        ce3 = 1'b0;
  logic [15:0] addr3, wdat3, sys3, dat3, port3, syso3, mwd3, mrd3;
  logic [14:0] ma3;
  logic [1:0]  mbe3;

  always @(posedge clk) ce3 <= ~ce3;

  vm1_bus_slave #(.RAM_TOP(16'o100000), .WAIT_STATES(0), .TIMEOUT(63)) dut0 (
    .clk(clk), .reset_n(rst0_n), .ce(ce0), .addr_i(addr0), .data_i(wdat0), .data_o(dat0),
    .SYNC(sync0), .DIN(din0), .DOUT(dout0), .WTBT(wtbt0), .RPLY(rply0), .error_o(err0),
    .mem_addr(ma0), .mem_wdata(mwd0), .mem_be(mbe0), .mem_en(men0), .mem_we(mwe0),
    .mem_rdata(mrd0), .port_o(port0), .sys_i(sys0), .sys_o(syso0));

  vm1_bus_slave #(.RAM_TOP(16'o100000), .WAIT_STATES(3), .TIMEOUT(63)) dut3 (
    .clk(clk), .reset_n(rst3_n), .ce(ce3), .addr_i(addr3), .data_i(wdat3), .data_o(dat3),
    .SYNC(sync3), .DIN(din3), .DOUT(dout3), .WTBT(wtbt3), .RPLY(rply3), .error_o(err3),
    .mem_addr(ma3), .mem_wdata(mwd3), .mem_be(mbe3), .mem_en(men3), .mem_we(mwe3),
    .mem_rdata(mrd3), .port_o(port3), .sys_i(sys3), .sys_o(syso3));

  // Synchronous RAM models: read data registered on the strobe and held.
  logic [15:0] ram0 [0:1023];
  logic [15:0] ram3 [0:63];
  always @(posedge clk) begin
    if (clr0) begin
      for (int i = 0; i < 1024; i++) ram0[i] <= '0;
    end else if (ce0 && men0) begin
      if (mwe0 && mbe0[0]) ram0[ma0[9:0]][7:0]  <= mwd0[7:0];
      if (mwe0 && mbe0[1]) ram0[ma0[9:0]][15:8] <= mwd0[15:8];
      mrd0 <= ram0[ma0[9:0]];
    end
  end
  always @(posedge clk) begin
    if (ce3 && men3) begin
      if (mwe3 && mbe3[0]) ram3[ma3[5:0]][7:0]  <= mwd3[7:0];
      if (mwe3 && mbe3[1]) ram3[ma3[5:0]][15:8] <= mwd3[15:8];
      mrd3 <= ram3[ma3[5:0]];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // lat: ce-edges from SYNC sample to RPLY (-1 = none); elat: same for error_o (0 = none).
  typedef struct {
    logic din, dout, wtbt, clr;
    logic [15:0] addr, wdata, sysv;
    int lat, elat, nen;
    logic we;
    logic [1:0] be;
    logic [15:0] wd;
    logic [14:0] maddr;
    logic [15:0] rdat, port, sysr;
  } vec_t;

  task automatic run0(input vec_t v, input int idx);
    int lat, elat, ecnt, nen;
    logic we;
    logic [1:0] be;
    logic [15:0] wd;
    logic [14:0] ma;
    string t;
    lat = -1; elat = 0; ecnt = 0; nen = 0; we = 0; be = 0; wd = 0; ma = 0;
    t = $sformatf("v%0d", idx);
    clr0 = v.clr; sync0 = 0; din0 = 0; dout0 = 0;
    tick;
    clr0 = 0;
    tick;
    addr0 = v.addr; wdat0 = v.wdata; wtbt0 = v.wtbt; sys0 = v.sysv;
    din0 = v.din; dout0 = v.dout; sync0 = 1;
    for (int k = 1; k <= 90; k++) begin
      tick;
      if (men0) begin nen++; we = mwe0; be = mbe0; wd = mwd0; ma = ma0; end
      if (err0) begin ecnt++; if (elat == 0) elat = k - 1; end
      if (rply0) begin lat = k - 1; break; end
      if (elat != 0 && k > elat + 3) break;
    end
    chk({t, " rply_lat"}, lat, v.lat);
    chk({t, " err_lat"}, elat, v.elat);
    chk({t, " err_width"}, ecnt, (v.elat != 0) ? 1 : 0);
    chk({t, " mem_en_pulses"}, nen, v.nen);
    if (v.nen > 0) begin
      chk({t, " mem_we"}, we, v.we);
      chk({t, " mem_addr"}, ma, v.maddr);
      if (v.we) begin
        chk({t, " mem_be"}, be, v.be);
        chk({t, " mem_wdata"}, wd, v.wd);
      end
    end
    if (v.din && !v.dout && v.lat >= 0) chk({t, " data_o"}, dat0, v.rdat);
    sync0 = 0; din0 = 0; dout0 = 0;
    tick;
    chk({t, " rply_fall"}, rply0, 1'b0);
    chk({t, " port_o"}, port0, v.port);
    chk({t, " sys_o"}, syso0, v.sysr);
  endtask

  task automatic cyc3(input logic di, input logic dw, input logic [15:0] a, input logic [15:0] d,
                      output int lat, output int elat, output int ewid);
    int act;
    sync3 = 0; din3 = 0; dout3 = 0;
    repeat (4) tick;
    addr3 = a; wdat3 = d; din3 = di; dout3 = dw; sync3 = 1;
    lat = -1; elat = 0; ewid = 0; act = 0;
    for (int k = 0; k < 300; k++) begin
      if (ce3) act++;
      tick;
      if (err3) begin ewid++; if (elat == 0) elat = act - 1; end
      else if (ewid > 0) break;
      if (rply3) begin lat = act - 1; break; end
    end
    sync3 = 0; din3 = 0; dout3 = 0;
    repeat (2) tick;
  endtask

  vec_t tbl[19];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int lat, elat, ewid, cnt;
    //          din   dout  wtbt  clr   addr        wdata       sysv    lat elat nen we    be     wd          maddr       rdat    port    sysr
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'o001000, 16'o123456, 16'hC0DE, 2, 0, 1, 1'b1, 2'b11, 16'o123456, 15'o000400, 16'h0,    16'h0,    16'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'o001001, 16'hFF00,   16'hC0DE, 2, 0, 1, 1'b1, 2'b10, 16'hFFFF,   15'o000400, 16'h0,    16'h0,    16'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'o001000, 16'h0,      16'hC0DE, 2, 0, 1, 1'b0, 2'b11, 16'h0,      15'o000400, 16'hFF00, 16'h0,    16'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'o177714, 16'h1234,   16'hC0DE, 1, 0, 0, 1'b0, 2'b00, 16'h0,      15'o0,      16'h0,    16'h1234, 16'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'o177715, 16'hAB00,   16'hC0DE, 1, 0, 0, 1'b0, 2'b00, 16'h0,      15'o0,      16'h0,    16'hAB34, 16'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'o177716, 16'h0,      16'hC0DE, 1, 0, 0, 1'b0, 2'b00, 16'h0,      15'o0,      16'hC0DE, 16'hAB34, 16'h0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'o160000, 16'h0,      16'hC0DE, -1, 64, 0, 1'b0, 2'b00, 16'h0,    15'o0,      16'h0,    16'hAB34, 16'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'o001000, 16'h5555,   16'hC0DE, -1, 64, 0, 1'b0, 2'b00, 16'h0,    15'o0,      16'h0,    16'hAB34, 16'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'o001000, 16'h0,      16'hC0DE, 2, 0, 1, 1'b0, 2'b11, 16'h0,      15'o000400, 16'hFF00, 16'hAB34, 16'h0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'o177716, 16'h12AB,   16'hC0DE, 1, 0, 0, 1'b0, 2'b00, 16'h0,      15'o0,      16'h0,    16'hAB34, 16'h00AB};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'o177714, 16'h0,      16'h5A5A, 1, 0, 0, 1'b0, 2'b00, 16'h0,      15'o0,      16'hAB34, 16'hAB34, 16'h00AB};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'o000002, 16'h0077,   16'hC0DE, 2, 0, 1, 1'b1, 2'b01, 16'h7777,   15'o000001, 16'h0,    16'hAB34, 16'h00AB};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'o000002, 16'h0,      16'hC0DE, 2, 0, 1, 1'b0, 2'b11, 16'h0,      15'o000001, 16'h0077, 16'hAB34, 16'h00AB};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'o000003, 16'hBEEF,   16'hC0DE, 2, 0, 1, 1'b1, 2'b11, 16'hBEEF,   15'o000001, 16'h0,    16'hAB34, 16'h00AB};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'o000002, 16'h0,      16'hC0DE, 2, 0, 1, 1'b0, 2'b11, 16'h0,      15'o000001, 16'hBEEF, 16'hAB34, 16'h00AB};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'o100000, 16'h0,      16'hC0DE, -1, 64, 0, 1'b0, 2'b00, 16'h0,    15'o0,      16'h0,    16'hAB34, 16'h00AB};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'o077776, 16'h0F0F,   16'hC0DE, 2, 0, 1, 1'b1, 2'b11, 16'h0F0F,   15'o037777, 16'h0,    16'hAB34, 16'h00AB};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'o077776, 16'h0,      16'hC0DE, 2, 0, 1, 1'b0, 2'b11, 16'h0,      15'o037777, 16'h0F0F, 16'hAB34, 16'h00AB};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'o000004, 16'h0,      16'hC0DE, 2, 0, 1, 1'b1, 2'b11, 16'h0,      15'o000002, 16'h0,    16'hAB34, 16'h00AB};

    rst0_n = 0; rst3_n = 0; ce0 = 1; clr0 = 0;
    sync0 = 0; din0 = 0; dout0 = 0; wtbt0 = 0; addr0 = 0; wdat0 = 0; sys0 = 0;
    sync3 = 0; din3 = 0; dout3 = 0; wtbt3 = 0; addr3 = 0; wdat3 = 0; sys3 = 0;
    repeat (3) tick;
    chk("rst RPLY", rply0, 1'b0);
    chk("rst error_o", err0, 1'b0);
    chk("rst mem_en", men0, 1'b0);
    chk("rst mem_we", mwe0, 1'b0);
    chk("rst mem_be", mbe0, 2'b00);
    chk("rst data_o", dat0, 16'h0);
    chk("rst port_o", port0, 16'h0);
    chk("rst sys_o", syso0, 16'h0);
    chk("rst3 data_o", dat3, 16'h0);
    rst0_n = 1; rst3_n = 1;
    tick;

    for (int i = 0; i < 19; i++) run0(tbl[i], i);

    // Timeout abandoned after 10 cycles: no error, no reply, then a normal cycle works.
    sync0 = 0; repeat (2) tick;
    addr0 = 16'o160000; din0 = 1; dout0 = 0; sync0 = 1;
    cnt = 0;
    repeat (10) begin tick; cnt += int'(err0) + int'(rply0); end
    sync0 = 0; din0 = 0;
    repeat (80) begin tick; cnt += int'(err0) + int'(rply0); end
    chk("tout_abort no err/rply", cnt, 0);
    run0(tbl[14], 100);

    // SYNC dropped right after the RAM strobe: write lands, no reply.
    sync0 = 0; repeat (2) tick;
    addr0 = 16'o000004; wdat0 = 16'h1111; wtbt0 = 0; dout0 = 1; din0 = 0; sync0 = 1;
    tick;
    chk("drop mem_en", men0, 1'b1);
    sync0 = 0; dout0 = 0;
    cnt = 0;
    repeat (10) begin tick; cnt += int'(rply0); end
    chk("drop no rply", cnt, 0);
    v = tbl[14]; v.addr = 16'o000004; v.maddr = 15'o000002; v.rdat = 16'h1111;
    run0(v, 101);

    // Back-to-back without an idle SYNC low sample must not start a cycle.
    sync0 = 0; repeat (2) tick;
    addr0 = 16'o177714; din0 = 1; dout0 = 0; sync0 = 1;
    repeat (3) tick;
    chk("b2b first rply", rply0, 1'b1);
    sync0 = 0;
    tick;
    sync0 = 1;
    cnt = 0;
    repeat (10) begin tick; cnt += int'(rply0) + int'(err0); end
    chk("b2b no rearm", cnt, 0);
    sync0 = 0; din0 = 0;
    repeat (2) tick;

    // Three wait states with ce at half rate.
    cyc3(1'b0, 1'b1, 16'o000100, 16'h4321, lat, elat, ewid);
    chk("ws3 write lat", lat, 5);
    cyc3(1'b1, 1'b0, 16'o000100, 16'h0, lat, elat, ewid);
    chk("ws3 read lat", lat, 5);
    chk("ws3 read data", dat3, 16'h4321);

    // Reset pulsed while in WAIT aborts the cycle silently.
    sync3 = 0; repeat (4) tick;
    addr3 = 16'o000100; din3 = 1; dout3 = 0; sync3 = 1;
    cnt = 0;
    while (cnt < 3) begin if (ce3) cnt++; tick; end
    rst3_n = 0;
    tick;
    rst3_n = 1;
    chk("ws3 rst data_o", dat3, 16'h0);
    cnt = 0;
    repeat (30) begin tick; cnt += int'(rply3); end
    chk("ws3 rst no rply", cnt, 0);
    cyc3(1'b1, 1'b0, 16'o000100, 16'h0, lat, elat, ewid);
    chk("ws3 post-rst lat", lat, 5);
    chk("ws3 post-rst data", dat3, 16'h4321);

    // Timeout under ce gating: pulse lasts one ce-cycle (two clocks).
    cyc3(1'b1, 1'b0, 16'o170000, 16'h0, lat, elat, ewid);
    chk("ws3 tout rply", lat, -1);
    chk("ws3 tout err_lat", elat, 64);
    chk("ws3 tout err_width", ewid, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vm1_bus_slave.md
Name: vm1_bus_slave

Overview:
- Q-bus-style slave directly downstream of the vm1 bus interface. Consumes SYNC/DIN/DOUT/WTBT plus the address/data buses and generates RPLY.
- Maps CPU cycles onto a synchronous word-wide RAM port and two on-chip registers at 177714/177716.
- For unmapped addresses it raises a bus-timeout error instead of replying, so the CPU's error_i path can trap.

Parameters:
- RAM_TOP, 16'o100000: first byte address NOT backed by RAM. RAM covers 0..RAM_TOP-1.
- WAIT_STATES, 0: extra ce-cycles inserted between memory access and RPLY (0..15).
- TIMEOUT, 63: ce-cycles an unmapped cycle waits before error_o (1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- ce  in  1  clock enable; all state advances only when ce=1
- addr_i  in  16  CPU byte address (vm1 addr_o)
- data_i  in  16  CPU write data (vm1 data_o)
- data_o  out  16  read data to CPU (vm1 data_i)
- SYNC  in  1  bus cycle active
- DIN  in  1  read cycle
- DOUT  in  1  write cycle
- WTBT  in  1  byte operation
- RPLY  out  1  reply to DIN/DOUT
- error_o  out  1  bus timeout pulse (to vm1 error_i)
- mem_addr  out  15  RAM word address (addr_i[15:1])
- mem_wdata  out  16  RAM write data
- mem_be  out  2  byte enables {hi,lo}
- mem_en  out  1  RAM access strobe, one ce-cycle
- mem_we  out  1  RAM write, qualified by mem_en
- mem_rdata  in  16  RAM read data, valid one ce-cycle after mem_en
- port_o  out  16  register 177714 contents
- sys_i  in  16  read value of 177716
- sys_o  out  16  last value written to 177716

Behaviour:
- Reset (reset_n=0 at a clk edge, ce ignored): state=IDLE.
  - Outputs cleared: RPLY=0, error_o=0, mem_en=0, mem_we=0, mem_be=0, data_o=0, port_o=0, sys_o=0.
  - Reset mid-cycle aborts the cycle with no RPLY and no write completion.
- Cycle start:
  - In IDLE, SYNC=1 with exactly one of DIN/DOUT sampled on a ce edge latches addr, data_i, WTBT and direction, then decodes.
  - DIN=DOUT=1, or SYNC=1 with neither strobe, is treated as unmapped.
- Decode:
  - RAM if addr<RAM_TOP.
  - REG if addr[15:1] equals 177714>>1 or 177716>>1.
  - Otherwise UNMAPPED.
- States:
  - IDLE: as above. A RAM hit goes to ACCESS. A REG hit goes to WAIT with cnt=WAIT_STATES. UNMAPPED goes to TOUT with cnt=TIMEOUT.
  - ACCESS: mem_en=1 for exactly this ce-cycle; mem_we=DOUT. Next state WAIT with cnt=WAIT_STATES.
  - WAIT: counts down. At cnt=0 it goes to REPLY. On the transition from a RAM read, data_o<=mem_rdata. On the transition from a REG read, data_o<=selected register.
  - REPLY: RPLY=1, data_o held. Stays until SYNC=0 is sampled, then goes to IDLE with RPLY=0 on the following ce edge. A write to REG takes effect on entry to REPLY.
  - TOUT: decrements cnt while SYNC=1. At cnt=0 it goes to ERR. SYNC=0 before expiry returns to IDLE silently.
  - ERR: error_o=1 for one ce-cycle, then HOLD.
  - HOLD: waits for SYNC=0, then IDLE. RPLY is never asserted on this path.
- Latency: a RAM cycle gives RPLY 2+WAIT_STATES ce-cycles after the SYNC sample. A REG cycle gives RPLY 1+WAIT_STATES ce-cycles after the SYNC sample.
- Byte writes (WTBT=1, DOUT):
  - addr[0]=0: mem_be=01, data from data_i[7:0] on both lanes.
  - addr[0]=1: mem_be=10, data from data_i[15:8] on both lanes.
  - Word writes use mem_be=11 and data_i unchanged. Word ops ignore addr[0].
  - REG byte writes update only the addressed byte.
- Reads always return the full word. The CPU selects the byte.
- 177714 reads port_o. 177716 reads sys_i.
- SYNC dropping during ACCESS/WAIT: the cycle completes internally (write is not cancelled once mem_en has fired), then returns to IDLE without RPLY.
- A new SYNC is not accepted until IDLE has seen SYNC=0 at least once. A back-to-back cycle needs a SYNC low sample.
- ce=0 freezes all state and outputs, including the error_o pulse width.

Test Plan:
- Reset, then word write 16'o001000<=16'o123456 (WAIT_STATES=0) -> mem_en/mem_we single pulse, mem_addr=15'o000400, mem_be=11, RPLY rises 2 ce-cycles after SYNC and falls 1 ce-cycle after SYNC drops.
- Byte write WTBT=1, addr 16'o001001, data_i=16'o000377<<8 -> mem_be=10, mem_wdata=16'hFFFF. Readback of word 001000 gives data_o=16'hFF00 (RAM model pre-cleared).
- Word write 177714<=16'h1234, then byte write 177714 (addr[0]=1, data_i[15:8]=8'hAB) -> port_o=16'h1234, then 16'hAB34. Read 177716 with sys_i=16'hC0DE -> data_o=16'hC0DE, RPLY after 1 ce-cycle.
- DIN at 16'o160000 with TIMEOUT=63 -> no RPLY, error_o=1 for exactly one ce-cycle 64 ce-cycles after the SYNC sample, no mem_en. State returns to IDLE after SYNC drops.
- WAIT_STATES=3, ce toggling 1/0 -> RPLY after 5 ce-asserted cycles. reset_n=0 pulsed in WAIT -> RPLY stays 0 and a subsequent read succeeds.
- SYNC with DIN=DOUT=1 -> treated as unmapped (error_o pulse, no write). SYNC dropped at cycle 10 of TOUT -> no error_o.
